// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared sizing constants for the register file
package register_file_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 2**ADDR_WIDTH;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/register_file_rf_register.sv
// rtl/register_file_rf_register.sv - one storage word with load enable and synchronous clear
module rf_register #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear wins over load so a reset edge always leaves the word at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 1-write / 3-read register file, R0 hardwired to zero
module register_file #(
   parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] RW,
   input  logic [DATA_WIDTH-1:0] PW,
   input  logic [ADDR_WIDTH-1:0] RA,
   output logic [DATA_WIDTH-1:0] PA,
   input  logic [ADDR_WIDTH-1:0] RB,
   output logic [DATA_WIDTH-1:0] PB,
   input  logic [ADDR_WIDTH-1:0] RD,
   output logic [DATA_WIDTH-1:0] PD
);
   import register_file_pkg::*;

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];

   // R0 has no storage; it is a constant entry in the read array.
   assign regs[ZERO_REG] = '0;

   for (genvar i = ZERO_REG + 1; i < DEPTH; i++) begin : g_reg
      logic load;

      assign load = enable && (RW == ADDR_WIDTH'(i));

      rf_register #(
         .WIDTH (DATA_WIDTH)
      ) u_reg (
         .clock (clock),
         .reset (reset),
         .load  (load),
         .d     (PW),
         .q     (regs[i])
      );
   end

   // Reads are pure muxes on stored state: no write-to-read bypass.
   assign PA = regs[RA];
   assign PB = regs[RB];
   assign PD = regs[RD];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [4:0]  RW;
   logic [31:0] PW;
   logic [4:0]  RA;
   logic [31:0] PA;
   logic [4:0]  RB;
   logic [31:0] PB;
   logic [4:0]  RD;
   logic [31:0] PD;

   int checks = 0;
   int errors = 0;

   // Reference: plain array of register contents; entry 0 never written.
   logic [31:0] model [32];

   typedef struct {
      logic        rst;
      logic        en;
      logic [4:0]  rw;
      logic [31:0] pw;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic [31:0] exp_pa;
      logic [31:0] exp_pb;
      logic [31:0] exp_pd;
   } vec_t;

   vec_t vecs [8];

   register_file dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .RW     (RW),
      .PW     (PW),
      .RA     (RA),
      .PA     (PA),
      .RB     (RB),
      .PB     (PB),
      .RD     (RD),
      .PD     (PD)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : model[a];
   endfunction

   task automatic set_write(input logic r, input logic e, input logic [4:0] w, input logic [31:0] d);
      reset = r;
      enable = e;
      RW = w;
      PW = d;
   endtask

   task automatic set_read(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      RA = a;
      RB = b;
      RD = c;
   endtask

   // Clock one edge and apply the architectural rules to the model.
   task automatic edge_step();
      @(posedge clock);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end else if (enable && RW != 5'd0) begin
         model[RW] = PW;
      end
      #1;
   endtask

   task automatic check_ports(input string tag);
      #1;
      chk({tag, "_pa"}, PA, ref_read(RA));
      chk({tag, "_pb"}, PB, ref_read(RB));
      chk({tag, "_pd"}, PD, ref_read(RD));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      set_write(1'b0, 1'b0, 5'd0, 32'd0);
      set_read(5'd0, 5'd0, 5'd0);

      // Table: expected outputs after each edge, written out by hand.
      vecs[0] = '{1'b1, 1'b1, 5'd3,  32'd99,        5'd3,  5'd0, 5'd3,  32'd0,        32'd0,        32'd0};
      vecs[1] = '{1'b0, 1'b1, 5'd3,  32'd99,        5'd3,  5'd0, 5'd3,  32'd99,       32'd0,        32'd99};
      vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd3, 5'd0,  32'd0,        32'd99,       32'd0};
      vecs[3] = '{1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd3, 5'd5,  32'd0,        32'd99,       32'd0};
      vecs[4] = '{1'b0, 1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd7, 5'd7,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      vecs[5] = '{1'b0, 1'b1, 5'd31, 32'd1,         5'd31, 5'd7, 5'd0,  32'd1,        32'h1234_5678, 32'd0};
      vecs[6] = '{1'b0, 1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd3, 5'd31, 32'hA5A5_A5A5, 32'd99,       32'd1};
      vecs[7] = '{1'b1, 1'b0, 5'd0,  32'd0,         5'd7,  5'd3, 5'd31, 32'd0,        32'd0,        32'd0};

      for (int v = 0; v < 8; v++) begin
         set_write(vecs[v].rst, vecs[v].en, vecs[v].rw, vecs[v].pw);
         set_read(vecs[v].ra, vecs[v].rb, vecs[v].rd);
         edge_step();
         #1;
         chk($sformatf("tbl%0d_pa", v), PA, vecs[v].exp_pa);
         chk($sformatf("tbl%0d_pb", v), PB, vecs[v].exp_pb);
         chk($sformatf("tbl%0d_pd", v), PD, vecs[v].exp_pd);
      end

      // 1: reset then sweep all selects
      set_write(1'b1, 1'b0, 5'd0, 32'd0);
      edge_step();
      set_write(1'b0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 32; i++) begin
         set_read(5'(i), 5'(31 - i), 5'(i + 5));
         #1;
         chk($sformatf("rst_sweep%0d_pa", i), PA, 32'd0);
         chk($sformatf("rst_sweep%0d_pb", i), PB, 32'd0);
         chk($sformatf("rst_sweep%0d_pd", i), PD, 32'd0);
      end

      // 2: sequential fill with old-before / new-after checks on PA
      for (int k = 0; k < 32; k++) begin
         set_write(1'b0, 1'b1, 5'(k), 32'(20 + k));
         set_read(5'(k), 5'(k - 1), 5'(k - 2));
         #1;
         chk($sformatf("fill%0d_pre_pa", k), PA, 32'd0);
         edge_step();
         chk($sformatf("fill%0d_post_pa", k), PA, (k == 0) ? 32'd0 : 32'(20 + k));
         check_ports($sformatf("fill%0d", k));
      end
      set_write(1'b0, 1'b0, 5'd0, 32'd0);
      set_read(5'd1, 5'd31, 5'd0);
      #1;
      chk("fill_r1", PA, 32'd21);
      chk("fill_r31", PB, 32'd51);
      chk("fill_r0", PD, 32'd0);

      // 3: write disabled
      set_write(1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF);
      set_read(5'd5, 5'd5, 5'd5);
      for (int i = 0; i < 3; i++) edge_step();
      #1;
      chk("wdis_r5", PA, 32'd25);

      // 4: triple-port same address, read-during-write
      set_write(1'b0, 1'b1, 5'd7, 32'h1234_5678);
      edge_step();
      set_write(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5);
      set_read(5'd7, 5'd7, 5'd7);
      #1;
      chk("same_pre_pa", PA, 32'h1234_5678);
      chk("same_pre_pb", PB, 32'h1234_5678);
      chk("same_pre_pd", PD, 32'h1234_5678);
      edge_step();
      #1;
      chk("same_post_pa", PA, 32'hA5A5_A5A5);
      chk("same_post_pb", PB, 32'hA5A5_A5A5);
      chk("same_post_pd", PD, 32'hA5A5_A5A5);

      // 5: reset beats write at the same edge
      set_write(1'b1, 1'b1, 5'd3, 32'd99);
      set_read(5'd3, 5'd7, 5'd20);
      edge_step();
      #1;
      chk("rstpri_r3", PA, 32'd0);
      chk("rstpri_r7", PB, 32'd0);
      set_write(1'b0, 1'b1, 5'd3, 32'd99);
      edge_step();
      #1;
      chk("rstpri_w_r3", PA, 32'd99);

      // 6: R0 immunity, then everything else unchanged
      for (int i = 1; i < 32; i++) begin
         set_write(1'b0, 1'b1, 5'(i), $urandom);
         edge_step();
      end
      set_write(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      set_read(5'd0, 5'd0, 5'd0);
      edge_step();
      set_write(1'b0, 1'b0, 5'd0, 32'd0);
      #1;
      chk("r0_imm_pa", PA, 32'd0);
      for (int i = 0; i < 32; i++) begin
         set_read(5'(i), 5'(i), 5'(i));
         check_ports($sformatf("r0_imm_sweep%0d", i));
      end

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         set_write(($urandom_range(0, 24) == 0), 1'($urandom), 5'($urandom), $urandom);
         set_read(5'($urandom), 5'($urandom), 5'($urandom));
         check_ports($sformatf("rnd%0d_pre", n));
         edge_step();
         check_ports($sformatf("rnd%0d_post", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
